// File: rtl/spi_transaction_master_pkg.sv
// Shared types and constants for the SPI transaction master and the units it serves.
package spi_transaction_master_pkg;

  typedef enum logic [5:0] {
    S_IDLE     = 6'b000001,
    S_START    = 6'b000010,
    S_TX       = 6'b000100,
    S_WAIT_RSP = 6'b001000,
    S_RX       = 6'b010000,
    S_DONE     = 6'b100000
  } state_t;

  localparam int DefMaxTxBits = 68;
  localparam int DefRxBits    = 32;

  localparam int LenAlu     = 68;
  localparam int LenShifter = 68;
  localparam int LenMult    = 64;

  localparam int SlaveAlu     = 0;
  localparam int SlaveShifter = 1;
  localparam int SlaveMult    = 2;

endpackage

// File: rtl/spi_timeout_counter.sv
// Down-counting watchdog: loaded on clear, expires on the TimeoutCycles-th enabled cycle.
// TimeoutCycles == 0 disables it.
module spi_timeout_counter #(
  parameter int TimeoutCycles = 256
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  if (TimeoutCycles == 0) begin : g_off
    logic w_unused;
    assign w_unused  = ^{i_clock, i_reset, i_clear, i_enable};
    assign o_expired = 1'b0;
  end else begin : g_on
    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] LoadVal = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] r_count;

    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
        r_count <= '0;
      end else if (i_clear) begin
        r_count <= LoadVal;
      end else if (i_enable && (r_count != '0)) begin
        r_count <= r_count - CntW'(1);
      end
    end

    assign o_expired = i_enable && (r_count == '0);
  end

endmodule

// File: rtl/spi_transaction_master.sv
// One-shot SPI request/response engine shared by the serial functional units.
// States: IDLE wait req | START wait slave idle | TX shift packet | WAIT_RSP wait start bit | RX shift reply | DONE pulse result
module spi_transaction_master
  import spi_transaction_master_pkg::*;
#(
  parameter int NumSlaves     = 3,
  parameter int MaxTxBits     = DefMaxTxBits,
  parameter int RxBits        = DefRxBits,
  parameter int TimeoutCycles = 256
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_req_valid,
  output logic                           o_req_ready,
  input  logic [$clog2(NumSlaves)-1:0]   i_req_slave,
  input  logic [MaxTxBits-1:0]           i_req_data,
  input  logic [$clog2(MaxTxBits+1)-1:0] i_req_len,
  output logic                           o_rsp_valid,
  output logic [RxBits-1:0]              o_rsp_data,
  output logic                           o_rsp_error,
  output logic                           o_spi_sclk,
  output logic [NumSlaves-1:0]           o_spi_nss,
  output logic                           o_spi_mosi,
  input  logic                           i_spi_miso
);

  localparam int SlvW = $clog2(NumSlaves);
  localparam int LenW = $clog2(MaxTxBits + 1);
  localparam int CntW = (LenW > $clog2(RxBits)) ? LenW : $clog2(RxBits);
  localparam logic [SlvW-1:0] LastSlave = SlvW'(NumSlaves - 1);
  localparam logic [LenW-1:0] MaxLen    = LenW'(MaxTxBits);
  localparam logic [CntW-1:0] RxLast    = CntW'(RxBits - 1);

  state_t               r_state, w_state_next;
  logic [SlvW-1:0]      r_slave;
  logic [MaxTxBits-1:0] r_data;
  logic [LenW-1:0]      r_len;
  logic [CntW-1:0]      r_bit_cnt;
  logic [RxBits-1:0]    r_rx;
  logic [RxBits-1:0]    r_rsp_data;
  logic                 r_err;

  logic                 w_accept, w_req_bad, w_fail, w_tx_last, w_rx_last, w_to_done;
  logic                 w_tmo_clear, w_tmo_enable, w_tmo_expired;
  logic [NumSlaves-1:0] w_nss_sel;

  assign w_accept     = i_req_valid && o_req_ready;
  assign w_req_bad    = (i_req_len == '0) || (i_req_len > MaxLen) || (i_req_slave > LastSlave);
  assign w_tx_last    = (r_bit_cnt == (CntW'(r_len) - CntW'(1)));
  assign w_rx_last    = (r_bit_cnt == RxLast);
  assign w_to_done    = (w_state_next == S_DONE) && (r_state != S_DONE);
  assign w_tmo_enable = (r_state == S_START) || (r_state == S_WAIT_RSP);
  assign w_tmo_clear  = ((w_state_next == S_START) && (r_state != S_START)) ||
                        ((w_state_next == S_WAIT_RSP) && (r_state != S_WAIT_RSP));
  assign w_nss_sel    = ~(NumSlaves'(1) << r_slave);

  spi_timeout_counter #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_tmo_clear),
    .i_enable (w_tmo_enable),
    .o_expired(w_tmo_expired)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // A slave edge on miso in the expiry cycle still advances the transaction.
  always_comb begin
    w_state_next = r_state;
    w_fail       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_bad) begin
            w_state_next = S_DONE;
            w_fail       = 1'b1;
          end else begin
            w_state_next = S_START;
          end
        end
      end
      S_START: begin
        if (!i_spi_miso) begin
          w_state_next = S_TX;
        end else if (w_tmo_expired) begin
          w_state_next = S_DONE;
          w_fail       = 1'b1;
        end
      end
      S_TX:     if (w_tx_last) w_state_next = S_WAIT_RSP;
      S_WAIT_RSP: begin
        if (i_spi_miso) begin
          w_state_next = S_RX;
        end else if (w_tmo_expired) begin
          w_state_next = S_DONE;
          w_fail       = 1'b1;
        end
      end
      S_RX:     if (w_rx_last) w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_rsp_error = 1'b0;
    o_spi_mosi  = 1'b0;
    o_spi_nss   = '1;
    case (r_state)
      S_IDLE:     o_req_ready = !i_reset;
      S_START: begin
        o_spi_mosi = 1'b1;
        o_spi_nss  = w_nss_sel;
      end
      S_TX: begin
        o_spi_mosi = r_data[0];
        o_spi_nss  = w_nss_sel;
      end
      S_WAIT_RSP: o_spi_nss = w_nss_sel;
      S_RX:       o_spi_nss = w_nss_sel;
      S_DONE: begin
        o_rsp_valid = 1'b1;
        o_rsp_error = r_err;
      end
      default: ;
    endcase
  end

  assign o_rsp_data = r_rsp_data;
  assign o_spi_sclk = i_clock;

  // Packet shifts out LSB first; the reply shifts in from the top so bit 0 lands at index 0.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_slave    <= '0;
      r_data     <= '0;
      r_len      <= '0;
      r_bit_cnt  <= '0;
      r_rx       <= '0;
      r_rsp_data <= '0;
      r_err      <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_accept) begin
        r_slave <= i_req_slave;
        r_data  <= i_req_data;
        r_len   <= i_req_len;
      end else if (r_state == S_TX) begin
        r_data <= r_data >> 1;
      end
      if (((r_state == S_TX) && !w_tx_last) || ((r_state == S_RX) && !w_rx_last)) begin
        r_bit_cnt <= r_bit_cnt + CntW'(1);
      end else begin
        r_bit_cnt <= '0;
      end
      if (r_state == S_RX) begin
        r_rx <= {i_spi_miso, r_rx[RxBits-1:1]};
      end
      if (w_to_done) begin
        r_err      <= w_fail;
        r_rsp_data <= w_fail ? '0 : {i_spi_miso, r_rx[RxBits-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_spi_transaction_master.sv
// Table-driven bench with a scripted slave and a response scoreboard for spi_transaction_master.
module tb_spi_transaction_master;
  import spi_transaction_master_pkg::*;

  localparam int NS  = 3;
  localparam int TXB = 68;
  localparam int RXB = 32;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_slave;
  logic [67:0] req_data;
  logic [6:0]  req_len;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        sclk;
  logic [2:0]  nss;
  logic        mosi;
  logic        miso;

  always #5 clk = ~clk;

  spi_transaction_master #(
    .NumSlaves(NS), .MaxTxBits(TXB), .RxBits(RXB), .TimeoutCycles(TMO)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_slave(req_slave),
    .i_req_data (req_data),
    .i_req_len  (req_len),
    .o_rsp_valid(rsp_valid),
    .o_rsp_data (rsp_data),
    .o_rsp_error(rsp_error),
    .o_spi_sclk (sclk),
    .o_spi_nss  (nss),
    .o_spi_mosi (mosi),
    .i_spi_miso (miso)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc_cyc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          slave;
    int          len;
    logic [67:0] data;
    int          busy;
    int          wait_c;
    logic [31:0] rsp;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_bad(input vec_t v);
    return (v.len == 0) || (v.len > TXB) || (v.slave >= NS);
  endfunction

  // Cycles from the accept edge to the DONE cycle, counting both START and DONE.
  function automatic int exp_lat(input vec_t v);
    if (is_bad(v)) return 1;
    if (v.busy >= TMO) return TMO + 1;
    if (v.wait_c == 0) return v.busy + 1 + v.len + TMO + 1;
    return v.busy + 1 + v.len + v.wait_c + RXB + 1;
  endfunction

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got valid with data 0x%0h, want no response", rsp_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_data", 68'(rsp_data), 68'(e.data));
        check("rsp_error", 68'(rsp_error), 68'(e.err));
        check("latency", 68'(cyc - e.acc_cyc + 1), 68'(e.lat));
      end
    end
  end

  // Called on a negedge; returns on the negedge of the DONE cycle.
  task automatic run_txn(input vec_t v, input bit hold, output int acc_cyc, output int done_cyc);
    int guard;
    int bad_mosi;
    int bad_nss;
    logic [2:0] sel;
    sel       = ~(3'b001 << v.slave);
    req_slave = 2'(v.slave);
    req_len   = 7'(v.len);
    req_data  = v.data;
    req_valid = 1'b1;
    miso      = (v.busy > 0);
    guard     = 0;
    acc_cyc   = 0;
    while (req_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      check("accept_wait", 68'(guard), 68'(0));
      req_valid = 1'b0;
      done_cyc  = cyc;
      return;
    end
    acc_cyc = cyc + 1;
    sb.push_back('{data: v.exp_data, err: v.exp_err, acc_cyc: acc_cyc, lat: exp_lat(v)});
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    bad_mosi = 0;
    bad_nss  = 0;
    if (!is_bad(v)) begin
      for (int j = 1; j <= TMO; j++) begin
        if (j > 1) @(negedge clk);
        if (mosi !== 1'b1) bad_mosi++;
        if (nss !== sel) bad_nss++;
        miso = (j <= v.busy);
        if (j > v.busy) break;
      end
      if (v.busy < TMO) begin
        for (int i = 0; i < v.len; i++) begin
          @(negedge clk);
          if (mosi !== v.data[i]) bad_mosi++;
          if (nss !== sel) bad_nss++;
        end
        for (int k = 1; k <= TMO; k++) begin
          @(negedge clk);
          if (mosi !== 1'b0) bad_mosi++;
          if (nss !== sel) bad_nss++;
          miso = (k == v.wait_c);
          if (k == v.wait_c) break;
        end
        if (v.wait_c != 0) begin
          for (int i = 0; i < RXB; i++) begin
            @(negedge clk);
            if (nss !== sel) bad_nss++;
            miso = v.rsp[i];
          end
        end
      end
      @(negedge clk);
      miso = 1'b0;
    end
    check("mosi_bits", 68'(bad_mosi), 68'(0));
    check("nss_active", 68'(bad_nss), 68'(0));
    check("done_valid", 68'(rsp_valid), 68'(1));
    check("done_nss_idle", 68'(nss), 68'(3'b111));
    check("done_mosi", 68'(mosi), 68'(0));
    check("done_ready_low", 68'(req_ready), 68'(0));
    done_cyc = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0, a1, d1;
    vecs[0]  = '{slave: SlaveAlu, len: LenAlu, data: {32'd5, 32'd2, 4'h0}, busy: 0, wait_c: 3,
                 rsp: 32'd7, exp_err: 1'b0, exp_data: 32'd7};
    vecs[1]  = '{slave: SlaveMult, len: LenMult, data: {4'h0, 32'd7, 32'd6}, busy: 0, wait_c: 1,
                 rsp: 32'd42, exp_err: 1'b0, exp_data: 32'd42};
    vecs[2]  = '{slave: SlaveShifter, len: LenShifter, data: 68'hF_1234_5678_9ABC_DEF0, busy: 0, wait_c: 2,
                 rsp: 32'hA5A5_0F0F, exp_err: 1'b0, exp_data: 32'hA5A5_0F0F};
    vecs[3]  = '{slave: 0, len: 1, data: 68'h1, busy: 0, wait_c: 1,
                 rsp: 32'h8000_0001, exp_err: 1'b0, exp_data: 32'h8000_0001};
    vecs[4]  = '{slave: 3, len: 10, data: 68'h3FF, busy: 0, wait_c: 1,
                 rsp: 32'h0, exp_err: 1'b1, exp_data: 32'h0};
    vecs[5]  = '{slave: 0, len: 0, data: 68'h1, busy: 0, wait_c: 1,
                 rsp: 32'h0, exp_err: 1'b1, exp_data: 32'h0};
    vecs[6]  = '{slave: 1, len: 69, data: 68'h1, busy: 0, wait_c: 1,
                 rsp: 32'h0, exp_err: 1'b1, exp_data: 32'h0};
    vecs[7]  = '{slave: 1, len: 8, data: 68'h5A, busy: 0, wait_c: 0,
                 rsp: 32'h0, exp_err: 1'b1, exp_data: 32'h0};
    vecs[8]  = '{slave: 2, len: 8, data: 68'hC3, busy: 16, wait_c: 1,
                 rsp: 32'h0, exp_err: 1'b1, exp_data: 32'h0};
    vecs[9]  = '{slave: 0, len: 8, data: 68'h96, busy: 15, wait_c: 1,
                 rsp: 32'h1357_9BDF, exp_err: 1'b0, exp_data: 32'h1357_9BDF};
    vecs[10] = '{slave: 2, len: 4, data: 68'hC, busy: 0, wait_c: 16,
                 rsp: 32'hDEAD_BEEF, exp_err: 1'b0, exp_data: 32'hDEAD_BEEF};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_slave = '0;
    req_data  = '0;
    req_len   = '0;
    miso      = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_nss", 68'(nss), 68'(3'b111));
    check("reset_mosi", 68'(mosi), 68'(0));
    check("reset_valid", 68'(rsp_valid), 68'(0));
    check("reset_error", 68'(rsp_error), 68'(0));
    check("reset_data", 68'(rsp_data), 68'(0));
    rst = 1'b0;
    #1;
    check("reset_ready", 68'(req_ready), 68'(1));
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i], 1'b0, a0, d0);
      @(negedge clk);
      check("valid_one_cycle", 68'(rsp_valid), 68'(0));
      check("rsp_hold", 68'(rsp_data), 68'(vecs[i].exp_data));
      repeat (2) @(negedge clk);
    end

    // Back-to-back with valid held high, slave 0 then slave 1.
    run_txn(vecs[0], 1'b1, a0, d0);
    run_txn(vecs[2], 1'b0, a1, d1);
    check("b2b_accept_gap", 68'(a1 - d0), 68'(2));
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of TX bit 20.
    req_slave = 2'(vecs[2].slave);
    req_len   = 7'(vecs[2].len);
    req_data  = vecs[2].data;
    req_valid = 1'b1;
    check("pre_reset_ready", 68'(req_ready), 68'(1));
    @(negedge clk);
    req_valid = 1'b0;
    repeat (21) @(negedge clk);
    check("pre_reset_mosi", 68'(mosi), 68'(vecs[2].data[20]));
    check("pre_reset_nss", 68'(nss), 68'(3'b101));
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_nss", 68'(nss), 68'(3'b111));
    check("async_reset_mosi", 68'(mosi), 68'(0));
    check("async_reset_valid", 68'(rsp_valid), 68'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_ready", 68'(req_ready), 68'(1));
    check("post_reset_data", 68'(rsp_data), 68'(0));
    repeat (120) @(negedge clk);

    run_txn(vecs[3], 1'b0, a0, d0);
    repeat (3) @(negedge clk);

    check("scoreboard_empty", 68'(sb.size()), 68'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
